// File: rtl/nor_share_sched_if.sv
// rtl/nor_share_sched_if.sv - request/operand/result bundle for the shared NOR scheduler
//
// Purpose: groups the four-lane request, operand, clear and result signals.
// Ports (all 4 bits wide, bit i = lane i, except busy):
//   req, inp_a, inp_b, clr_valid : requester -> scheduler
//   gnt, done, out_res, res_valid : scheduler -> requester
//   busy (1 bit)                  : scheduler -> requester
// Modports: master (requester side), slave (scheduler side).
interface nor_share_sched_if;
  logic [3:0] req;
  logic [3:0] inp_a;
  logic [3:0] inp_b;
  logic [3:0] clr_valid;
  logic [3:0] gnt;
  logic [3:0] done;
  logic [3:0] out_res;
  logic [3:0] res_valid;
  logic       busy;

  modport master (
    output req, inp_a, inp_b, clr_valid,
    input  gnt, done, out_res, res_valid, busy
  );

  modport slave (
    input  req, inp_a, inp_b, clr_valid,
    output gnt, done, out_res, res_valid, busy
  );
endinterface

// File: rtl/nor_share_sched.sv
// rtl/nor_share_sched.sv - round-robin time-shared registered NOR unit for four lanes
//
// Purpose: one 2-input NOR evaluation unit shared by four lanes. A lane is
// picked round-robin, its operands are latched on the grant edge, the unit
// evaluates for LAT cycles, then the result is written to that lane's held
// result bit and a one-cycle done pulse is issued.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : nor_share_sched_if.slave (req, inp_a, inp_b, clr_valid in;
//           gnt, done, out_res, res_valid, busy out)
module nor_share_sched #(
  parameter int LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  nor_share_sched_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t     state, state_nx;
  logic [3:0] gnt_q, gnt_nx;
  logic [3:0] done_q, done_nx;
  logic [3:0] res_q, res_nx;
  logic [3:0] vld_q, vld_nx;
  logic [3:0] cnt_q, cnt_nx;
  logic [1:0] ptr_q, ptr_nx;
  logic [1:0] win_q, win_nx;
  logic       opa_q, opa_nx;
  logic       opb_q, opb_nx;
  logic [1:0] pick;
  logic       found;

  // First requesting lane at or above ptr, wrapping 3 -> 0.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && bus.req[ptr_q + 2'(i)]) begin
        pick  = ptr_q + 2'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_q;
    done_nx  = done_q;
    res_nx   = res_q;
    // A clear applies every cycle; a same-edge result write below overrides it.
    vld_nx   = vld_q & ~bus.clr_valid;
    cnt_nx   = cnt_q;
    ptr_nx   = ptr_q;
    win_nx   = win_q;
    opa_nx   = opa_q;
    opb_nx   = opb_q;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nx   = 4'b0001 << pick;
          win_nx   = pick;
          opa_nx   = bus.inp_a[pick];
          opb_nx   = bus.inp_b[pick];
          cnt_nx   = 4'(LAT - 1);
          state_nx = EVAL;
        end
      end
      EVAL: begin
        if (cnt_q != 4'd0) begin
          cnt_nx = cnt_q - 4'd1;
        end else begin
          res_nx[win_q] = ~(opa_q | opb_q);
          vld_nx[win_q] = 1'b1;
          done_nx       = 4'b0001 << win_q;
          gnt_nx        = 4'b0000;
          state_nx      = DONE;
        end
      end
      DONE: begin
        done_nx  = 4'b0000;
        // Lane just served goes to the back of the round-robin order.
        ptr_nx   = win_q + 2'd1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt_q  <= 4'b0000;
      done_q <= 4'b0000;
      res_q  <= 4'b0000;
      vld_q  <= 4'b0000;
      cnt_q  <= 4'd0;
      ptr_q  <= 2'd0;
      win_q  <= 2'd0;
      opa_q  <= 1'b0;
      opb_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      gnt_q  <= gnt_nx;
      done_q <= done_nx;
      res_q  <= res_nx;
      vld_q  <= vld_nx;
      cnt_q  <= cnt_nx;
      ptr_q  <= ptr_nx;
      win_q  <= win_nx;
      opa_q  <= opa_nx;
      opb_q  <= opb_nx;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.out_res   = res_q;
  assign bus.res_valid = vld_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_nor_share_sched.sv
// tb/tb_nor_share_sched.sv - scoreboard bench for nor_share_sched
module tb_nor_share_sched;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nor_share_sched_if bif ();

  nor_share_sched #(.LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic [1:0] lane;
    logic       res;
  } exp_t;

  exp_t       sb[$];
  int         done_cyc[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         done_seen = 0;
  int         gnt_cyc = 0;
  logic [3:0] gnt_prev = 4'b0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever a done pulse is presented.
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.gnt != 4'b0000 && gnt_prev == 4'b0000) gnt_cyc <= cyc;
      if (bif.done != 4'b0000) begin
        done_seen <= done_seen + 1;
        done_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(bif.done), 32'd0);
        end else begin
          check("done_lane", 32'(bif.done), 32'(4'b0001 << sb[0].lane));
          check("out_res_lane", 32'(bif.out_res[sb[0].lane]), 32'(sb[0].res));
          check("res_valid_lane", 32'(bif.res_valid[sb[0].lane]), 32'd1);
          check("grant_to_done", 32'(cyc - gnt_cyc), 32'(LAT));
          void'(sb.pop_front());
        end
      end
    end
    gnt_prev <= bif.gnt;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int lane, input logic res);
    exp_t e;
    e.lane = 2'(lane);
    e.res  = res;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, 32'(bif.gnt), 32'd0);
    check({tag, "_done"}, 32'(bif.done), 32'd0);
    check({tag, "_out_res"}, 32'(bif.out_res), 32'd0);
    check({tag, "_res_valid"}, 32'(bif.res_valid), 32'd0);
    check({tag, "_busy"}, 32'(bif.busy), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_zero(tag);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int n, input int budget);
    int tgt;
    int k;
    tgt = done_seen + n;
    k = 0;
    while (done_seen < tgt && k < budget) begin
      tick();
      k++;
    end
    if (done_seen < tgt) check("wait_done_timeout", 32'(done_seen), 32'(tgt));
  endtask

  task automatic wait_gnt(input logic [3:0] mask, input int budget);
    int k;
    k = 0;
    while (bif.gnt !== mask && k < budget) begin
      tick();
      k++;
    end
    if (bif.gnt !== mask) check("wait_gnt_timeout", 32'(bif.gnt), 32'(mask));
  endtask

  initial begin
    bif.req = 4'b0000;
    bif.inp_a = 4'b0000;
    bif.inp_b = 4'b0000;
    bif.clr_valid = 4'b0000;
    #2;

    // Single service on lane 0, NOR(0,0) = 1.
    do_reset("rst0");
    bif.req = 4'b0001;
    push(0, 1'b1);
    wait_done(1, 40);
    bif.req = 4'b0000;
    check("t1_done_one_cycle", 32'(bif.done), 32'd0);
    check("t1_res_valid", 32'(bif.res_valid), 32'h1);
    check("t1_out_res", 32'(bif.out_res), 32'h1);

    // Truth table across lanes: lane i gets (a,b) = (0,0),(0,1),(1,0),(1,1).
    do_reset("rst1");
    bif.inp_a = 4'b1100;
    bif.inp_b = 4'b1010;
    bif.req = 4'b1111;
    done_cyc.delete();
    push(0, 1'b1); push(1, 1'b0); push(2, 1'b0); push(3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_done(1, 40);
      bif.req[i] = 1'b0;
    end
    check("t2_out_res", 32'(bif.out_res), 32'h1);
    check("t2_res_valid", 32'(bif.res_valid), 32'hf);
    for (int i = 1; i < 4; i++)
      if (done_cyc.size() > i) check("t2_done_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'(LAT + 2));

    // Continuous requests: 12 services in strict round-robin order.
    do_reset("rst2");
    bif.inp_a = 4'b0101;
    bif.inp_b = 4'b0000;
    bif.req = 4'b1111;
    done_cyc.delete();
    for (int i = 0; i < 12; i++) push(i % 4, (i % 2) == 1);
    wait_done(12, 200);
    bif.req = 4'b0000;
    for (int i = 1; i < 12; i++)
      if (done_cyc.size() > i) check("t3_done_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'(LAT + 2));

    // Lane 2 operands and request change mid-service; latched values must win.
    do_reset("rst3");
    bif.inp_a = 4'b0100;
    bif.inp_b = 4'b0100;
    bif.req = 4'b0100;
    push(2, 1'b0);
    wait_gnt(4'b0100, 20);
    bif.req = 4'b0000;
    bif.inp_a = 4'b0000;
    bif.inp_b = 4'b0000;
    wait_done(1, 40);
    check("t4_out_res2", 32'(bif.out_res[2]), 32'd0);
    check("t4_res_valid", 32'(bif.res_valid), 32'h4);

    // Clear on the same edge as the write loses; a later clear takes effect.
    bif.req = 4'b0001;
    push(0, 1'b1);
    wait_gnt(4'b0001, 20);
    bif.req = 4'b0000;
    tick();
    bif.clr_valid = 4'b0001;
    tick();
    bif.clr_valid = 4'b0000;
    check("t5_write_beats_clear", 32'(bif.res_valid[0]), 32'd1);
    bif.clr_valid = 4'b0001;
    tick();
    bif.clr_valid = 4'b0000;
    check("t5_cleared", 32'(bif.res_valid), 32'h4);
    check("t5_out_res_held", 32'(bif.out_res), 32'h1);

    // Move ptr to 2, then abort a lane 1 service by reset.
    bif.inp_a = 4'b0000;
    bif.inp_b = 4'b0010;
    bif.req = 4'b0010;
    push(1, 1'b0);
    wait_done(1, 40);
    bif.req = 4'b0000;
    tick();
    bif.inp_a = 4'b0010;
    bif.req = 4'b0010;
    wait_gnt(4'b0010, 20);
    bif.req = 4'b0000;
    tick();
    do_reset("t6_abort");
    tick();
    check("t6_no_done_after_abort", 32'(bif.res_valid), 32'd0);
    // From ptr=0 lane 1 must win over lane 3.
    bif.inp_a = 4'b0000;
    bif.inp_b = 4'b0000;
    bif.req = 4'b1010;
    push(1, 1'b1); push(3, 1'b1);
    wait_done(1, 40);
    bif.req = 4'b1000;
    wait_done(1, 40);
    bif.req = 4'b0000;
    tick();
    tick();
    check("t6_out_res", 32'(bif.out_res), 32'ha);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
